tile_array_cfg_loader: RTL and testbench

- Configuration loader for a parametrised ROWS x COLS tile array.
- Accepts a packed bitstream over a valid/ready word interface and serialises it into the two array scan chains, CLB first, then connection.
- Drives scan enables and a per-bit shift strobe. The fabric uses the strobe to gate scan_clk from clk.
- Sits between the host config port and the array's clb_scan_in / conn_scan_in.

---
 rtl/tile_cfg_pkg.sv | 26 ++
 rtl/cfg_word_unpacker.sv | 57 +++++
 rtl/tile_array_cfg_loader.sv | 140 ++++++++++++++
 tb/tb_tile_array_cfg_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tile_cfg_pkg.sv
// Shared types and helpers for the tile array configuration loader.
// No logic of its own: FSM state encoding, CRC constants, chain length helpers.
package tile_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLB_SHIFT  = 2'd1,
        CONN_SHIFT = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic int chain_len(input int rows, input int cols, input int bits);
        return rows * cols * bits;
    endfunction

    // One MSB-first CRC-16-CCITT step for a single incoming bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_word_unpacker.sv
// Word buffer: accepts WORD_W-bit words on valid/ready and hands out one bit per take, LSB first.
// Ready only when empty or last bit is being taken (no-bubble refill); stops after TOT_LEN bits loaded.
module cfg_word_unpacker
    import tile_cfg_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TOT_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              bit_valid,
    output logic              bit_data,
    input  logic              bit_take
);

    localparam int LW = $clog2(TOT_LEN + 1);
    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [LW-1:0] TOT_L  = LW'(TOT_LEN);
    localparam logic [LW-1:0] WORD_L = LW'(WORD_W);

    logic [WORD_W-1:0] word_q;
    logic [CW-1:0]     cnt_q;
    logic [LW-1:0]     loaded_q;
    logic [LW-1:0]     remain;
    logic [LW-1:0]     take_len;
    logic              accept;

    // The final word only contributes the bits still owed, so the tail is dropped here.
    assign remain   = TOT_L - loaded_q;
    assign take_len = (remain < WORD_L) ? remain : WORD_L;

    assign bit_valid = (cnt_q != '0);
    assign bit_data  = word_q[0];
    assign cfg_ready = active && (loaded_q != TOT_L) &&
                       ((cnt_q == '0) || ((cnt_q == CW'(1)) && bit_take));
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            word_q   <= '0;
            cnt_q    <= '0;
            loaded_q <= '0;
        end else if (accept) begin
            word_q   <= cfg_data;
            cnt_q    <= CW'(take_len);
            loaded_q <= loaded_q + take_len;
        end else if (bit_take) begin
            word_q   <= word_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/tile_array_cfg_loader.sv
// Serialises a packed bitstream into the CLB then connection scan chains, 1 bit/cycle after a 1-cycle fill.
// Stalls (scan_clk_en low) when the word buffer runs dry; CRC readback over scan outputs under CFG_READBACK_EN.
module tile_array_cfg_loader
    import tile_cfg_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int CLB_BITS  = 20,
    parameter int CONN_BITS = 96,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              clb_scan_en,
    output logic              clb_scan_in,
    input  logic              clb_scan_out,
    output logic              conn_scan_en,
    output logic              conn_scan_in,
    input  logic              conn_scan_out,
    output logic              scan_clk_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       rb_crc
);

    localparam int CLB_LEN  = chain_len(ROWS, COLS, CLB_BITS);
    localparam int CONN_LEN = chain_len(ROWS, COLS, CONN_BITS);
    localparam int TOT_LEN  = CLB_LEN + CONN_LEN;
    localparam int LW       = $clog2(TOT_LEN + 1);
    localparam logic [LW-1:0] CLB_LAST = LW'(CLB_LEN - 1);
    localparam logic [LW-1:0] TOT_LAST = LW'(TOT_LEN - 1);

    state_t        state_q, state_d;
    logic [LW-1:0] bit_cnt_q;
    logic          err_q;
    logic          clb_hold_q, conn_hold_q;
    logic          bit_valid, bit_data;
    logic          start_load;

    cfg_word_unpacker #(
        .WORD_W  (WORD_W),
        .TOT_LEN (TOT_LEN)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .active    (busy),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_take  (scan_clk_en)
    );

    assign start_load   = (state_q == IDLE) && start;
    assign clb_scan_en  = (state_q == CLB_SHIFT);
    assign conn_scan_en = (state_q == CONN_SHIFT);
    assign busy         = clb_scan_en || conn_scan_en;
    assign done         = (state_q == DONE);
    assign err          = err_q;
    assign scan_clk_en  = busy && bit_valid;

    // During a stall the active chain keeps seeing the last bit it was given.
    assign clb_scan_in  = clb_scan_en  ? (bit_valid ? bit_data : clb_hold_q)  : 1'b0;
    assign conn_scan_in = conn_scan_en ? (bit_valid ? bit_data : conn_hold_q) : 1'b0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLB_SHIFT;
            end
            CLB_SHIFT: begin
                if (abort)                                  state_d = IDLE;
                else if (scan_clk_en && bit_cnt_q == CLB_LAST) state_d = CONN_SHIFT;
            end
            CONN_SHIFT: begin
                if (abort)                                  state_d = IDLE;
                else if (scan_clk_en && bit_cnt_q == TOT_LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_load) begin
                bit_cnt_q <= '0;
                err_q     <= 1'b0;
            end else if (busy && abort) begin
                err_q     <= 1'b1;
            end else if (scan_clk_en) begin
                bit_cnt_q <= bit_cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            clb_hold_q  <= 1'b0;
            conn_hold_q <= 1'b0;
        end else if (scan_clk_en) begin
            if (clb_scan_en) clb_hold_q  <= bit_data;
            else             conn_hold_q <= bit_data;
        end
    end

`ifdef CFG_READBACK_EN
    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 16'h0000;
        end else if (start_load) begin
            crc_q <= CRC_INIT;
        end else if (scan_clk_en) begin
            crc_q <= crc16_step(crc_q, clb_scan_en ? clb_scan_out : conn_scan_out);
        end
    end

    assign rb_crc = crc_q;
`else
    logic unused_scan_out;
    assign unused_scan_out = clb_scan_out ^ conn_scan_out;
    assign rb_crc          = 16'h0000;
`endif

endmodule

// File: tb/tb_tile_array_cfg_loader.sv
// Directed bench for tile_array_cfg_loader on a 1x2 array (CLB_LEN=6, TOT_LEN=16, 8-bit words).
module tb_tile_array_cfg_loader;

    localparam int ROWS = 1, COLS = 2, CLB_BITS = 3, CONN_BITS = 5, WORD_W = 8;
    localparam int CLB_LEN = 6, TOT_LEN = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, abort = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data = '0;
    logic              clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in;
    logic              clb_scan_out = 1'b1, conn_scan_out = 1'b1;
    logic              scan_clk_en, busy, done, err;
    logic [15:0]       rb_crc;

    tile_array_cfg_loader #(
        .ROWS(ROWS), .COLS(COLS), .CLB_BITS(CLB_BITS), .CONN_BITS(CONN_BITS), .WORD_W(WORD_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .clb_scan_en(clb_scan_en), .clb_scan_in(clb_scan_in), .clb_scan_out(clb_scan_out),
        .conn_scan_en(conn_scan_en), .conn_scan_in(conn_scan_in), .conn_scan_out(conn_scan_out),
        .scan_clk_en(scan_clk_en), .busy(busy), .done(done), .err(err), .rb_crc(rb_crc)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    logic [1:0] exp_q[$];        // {chain (0=CLB,1=CONN), bit}
    logic [1:0] sb_e;
    int pushed, n_shifts, first_shift, last_shift, done_cnt, done_cyc, start_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] crc_ones(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ 1'b1) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every shift strobe must deliver the next expected bit on the right chain.
    always @(negedge clk) begin
        if (!rst && start && !busy && !done) start_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (scan_clk_en) begin
            if (n_shifts == 0) first_shift = cyc;
            last_shift = cyc;
            n_shifts++;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                if (sb_e[1] == 1'b0)
                    chk("clb_bit", {clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in},
                        {1'b1, sb_e[0], 2'b00});
                else
                    chk("conn_bit", {clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in},
                        {2'b00, 1'b1, sb_e[0]});
            end
        end
    end

    task automatic clear_mon();
        exp_q.delete();
        pushed = 0; n_shifts = 0; first_shift = -1; last_shift = -1;
        done_cnt = 0; done_cyc = -1; start_cyc = -1;
    endtask

    task automatic push_word(input logic [WORD_W-1:0] d);
        for (int i = 0; i < WORD_W; i++) begin
            if (pushed < TOT_LEN) begin
                exp_q.push_back({(pushed >= CLB_LEN) ? 1'b1 : 1'b0, d[i]});
                pushed++;
            end
        end
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input string tag);
        logic acc;
        acc = 1'b0;
        push_word(d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        if (!acc) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 100 && done_cnt == 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt == 0) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input bit gap, input bit mid_start, input bit with_abort);
        clear_mon();
        start = 1'b1;
        abort = with_abort;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        chk({tag, "_busy_err_after_start"}, {busy, err}, 2'b10);
        send_word(8'hA5, {tag, "_w0"});
        if (gap) begin
            step(12);
            chk({tag, "_stall_shifts"}, n_shifts, 8);
            chk({tag, "_stall_outputs"},
                {scan_clk_en, clb_scan_en, conn_scan_en, conn_scan_in, busy}, 5'b00111);
        end
        if (mid_start) begin
            start = 1'b1;
            step(1);
            start = 1'b0;
        end
        send_word(8'h3C, {tag, "_w1"});
        wait_done(tag);
        step(3);
        chk({tag, "_shift_count"}, n_shifts, TOT_LEN);
        chk({tag, "_done_after_last"}, done_cyc - last_shift, 1);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_idle_outputs"}, {busy, done, clb_scan_en, conn_scan_en, cfg_ready}, 5'b0);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        if (!gap) begin
            chk({tag, "_no_gap"}, last_shift - first_shift, TOT_LEN - 1);
            chk({tag, "_fill_latency"}, first_shift - start_cyc, 2);
            chk({tag, "_start_to_done"}, done_cyc - start_cyc, TOT_LEN + 2);
        end
`ifdef CFG_READBACK_EN
        chk({tag, "_rb_crc"}, rb_crc, crc_ones(TOT_LEN));
`else
        chk({tag, "_rb_crc"}, rb_crc, 16'h0000);
`endif
    endtask

    initial begin
        clear_mon();
        step(3);
        chk("reset_outputs",
            {cfg_ready, clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in,
             scan_clk_en, busy, done, err, rb_crc}, 25'd0);
        rst = 1'b0;
        step(2);

        // Abort while idle must not touch err.
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("idle_abort_err", {busy, err}, 2'b00);

        do_load("t1", 1'b0, 1'b0, 1'b0);
        do_load("t2_gap", 1'b1, 1'b0, 1'b0);

        // Abort after four bits have been shifted.
        clear_mon();
        start = 1'b1;
        step(1);
        start = 1'b0;
        send_word(8'hA5, "t3_w0");
        for (int t = 0; t < 50 && n_shifts < 4; t++) step(1);
        chk("t3_pre_abort_shifts", n_shifts, 4);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t3_abort_outputs", {busy, clb_scan_en, conn_scan_en, err, done, cfg_ready}, 6'b000100);
        exp_q.delete();
        step(4);
        chk("t3_no_done", done_cnt, 0);
        chk("t3_err_sticky", err, 1'b1);
        do_load("t3_restart", 1'b0, 1'b0, 1'b1);

        do_load("t4_midstart", 1'b0, 1'b1, 1'b0);

        // Reset during the connection chain.
        clear_mon();
        start = 1'b1;
        step(1);
        start = 1'b0;
        send_word(8'hA5, "t5_w0");
        send_word(8'h3C, "t5_w1");
        step(1);
        chk("t5_in_conn", {busy, conn_scan_en}, 2'b11);
        rst = 1'b1;
        step(1);
        chk("t5_reset_outputs",
            {cfg_ready, clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in,
             scan_clk_en, busy, done, err, rb_crc}, 25'd0);
        rst = 1'b0;
        step(2);
        do_load("t5_after_rst", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
